param_shift_register: RTL



---
 rtl/param_shift_register.sv | 99 +++++++++
 1 files changed

// File: rtl/param_shift_register.sv
// Parametrised universal shift register (hold / shift / rotate / load) with a
// saturating toggle counter that reports switching activity on q.
module param_shift_register #(
  parameter int WIDTH     = 4,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enb,
  input  logic [2:0]           mode,
  input  logic                 sin_lsb,
  input  logic                 sin_msb,
  input  logic [WIDTH-1:0]     d_in,
  input  logic                 cnt_clr,
  output logic [WIDTH-1:0]     q,
  output logic                 sout_msb,
  output logic                 sout_lsb,
  output logic [CNT_WIDTH-1:0] toggle_cnt,
  output logic                 cnt_sat
);

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_SHL  = 3'b001;
  localparam logic [2:0] MODE_SHR  = 3'b010;
  localparam logic [2:0] MODE_LOAD = 3'b011;
  localparam logic [2:0] MODE_ROL  = 3'b100;
  localparam logic [2:0] MODE_ROR  = 3'b101;

  // Six guard bits hold a popcount of up to 32, so the add can never wrap.
  localparam int               SUM_W   = CNT_WIDTH + 6;
  localparam logic [SUM_W-1:0] CNT_MAX = {{6{1'b0}}, {CNT_WIDTH{1'b1}}};

  logic [WIDTH-1:0]     r_q;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic                 r_sat;
  logic [WIDTH-1:0]     w_q_next;
  logic [WIDTH-1:0]     w_diff;
  logic [5:0]           w_pop;
  logic [SUM_W-1:0]     w_sum;
  logic [CNT_WIDTH-1:0] w_cnt_next;

  always_comb begin
    // NOTE: default assignment first so every path drives w_q_next; no latch.
    w_q_next = r_q;
    if (enb) begin
      case (mode)
        MODE_HOLD: w_q_next = r_q;
        MODE_SHL:  w_q_next = {r_q[WIDTH-2:0], sin_lsb};
        MODE_SHR:  w_q_next = {sin_msb, r_q[WIDTH-1:1]};
        MODE_LOAD: w_q_next = d_in;
        MODE_ROL:  w_q_next = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
        MODE_ROR:  w_q_next = {r_q[0], r_q[WIDTH-1:1]};
        default:   w_q_next = r_q;
      endcase
    end
  end

  assign w_diff = r_q ^ w_q_next;

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_pop = w_pop + 6'(w_diff[i]);
    end
  end

  assign w_sum      = {6'b0, r_cnt} + SUM_W'(w_pop);
  assign w_cnt_next = (w_sum > CNT_MAX) ? {CNT_WIDTH{1'b1}} : w_sum[CNT_WIDTH-1:0];

  // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else begin
      r_q <= w_q_next;
    end
  end

  // Clear wins over counting and works regardless of enb.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_sat <= 1'b0;
    end else if (cnt_clr) begin
      r_cnt <= '0;
      r_sat <= 1'b0;
    end else if (enb) begin
      r_cnt <= w_cnt_next;
      r_sat <= &w_cnt_next;
    end
  end

  assign q          = r_q;
  assign sout_msb   = r_q[WIDTH-1];
  assign sout_lsb   = r_q[0];
  assign toggle_cnt = r_cnt;
  assign cnt_sat    = r_sat;

endmodule
